// File: rtl/pack_str_pkg.sv
// Shared beat type for the pack_str lanes and the arbiter's state encoding.
package pack_str_pkg;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] payload;
    logic       last;
  } pack_str_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pack_str_arbiter_if.sv
// Request side (NUM_REQ lanes) and the single shared output channel of the arbiter.
interface pack_str_arbiter_if
  import pack_str_pkg::*;
#(
  parameter int NUM_REQ = 3
);
  localparam int GNT_W = $clog2(NUM_REQ);

  // Every stream here moves a beat on a cycle where valid and ready are both high;
  // a producer holds valid and data stable until that happens, ready never waits on a future cycle.
  logic [NUM_REQ-1:0] req_valid;
  pack_str_t          req_data [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic               out_valid;
  pack_str_t          out_data;
  logic [GNT_W-1:0]   out_grant;
  logic               out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_grant
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_grant
  );

endinterface

// File: rtl/pack_str_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping past NUM_REQ-1.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int GNT_W = $clog2(NUM_REQ);

  logic [GNT_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GNT_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/pack_str_arbiter.sv
// Round-robin burst arbiter sharing one registered pack_str_t channel among NUM_REQ lanes.
module pack_str_arbiter
  import pack_str_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  pack_str_arbiter_if.slave                bus,
  output logic                             busy,
  output arb_state_e                       dbg_state_o,
  output logic [$clog2(NUM_REQ)-1:0]       dbg_grant_o,
  output logic [$clog2(NUM_REQ)-1:0]       dbg_ptr_o,
  output logic [$clog2(MAX_BURST+1)-1:0]   dbg_beat_cnt_o
);
  localparam int GNT_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [GNT_W-1:0] grant_q, grant_d;
  logic [GNT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  pack_str_t        out_data_q, out_data_d;
  logic [GNT_W-1:0] out_grant_q, out_grant_d;

  logic [NUM_REQ-1:0] req_ready;
  logic               xfer;
  logic [GNT_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_grant_q <= out_grant_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_grant_d = out_grant_q;
    req_ready   = '0;
    xfer        = 1'b0;

    // A drained output register empties unless a new beat lands in the same cycle.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        req_ready[grant_q] = !out_valid_q || bus.out_ready;
        xfer = bus.req_valid[grant_q] && req_ready[grant_q];
        if (xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.req_data[grant_q];
          out_grant_d = grant_q;
          cnt_d       = cnt_q + CNT_W'(1);
        end
        // A dropped valid forfeits the rest of the burst but still advances the rotation.
        if ((xfer && cnt_q == CNT_W'(MAX_BURST - 1)) || !bus.req_valid[grant_q]) begin
          state_d = IDLE;
          ptr_d   = (grant_q == GNT_W'(NUM_REQ - 1)) ? '0 : grant_q + GNT_W'(1);
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_grant = out_grant_q;

  assign busy           = (state_q == BUSY);
  assign dbg_state_o    = state_q;
  assign dbg_grant_o    = grant_q;
  assign dbg_ptr_o      = ptr_q;
  assign dbg_beat_cnt_o = cnt_q;

endmodule
